warmboot_sequencer: RTL
=======================

# warmboot_sequencer

Sequences a controlled iCE40 warm reboot from the USB bootloader into a selected flash image. The block sits between the bootloader core and the `SB_WARMBOOT` primitive:
- It accepts a boot request.
- It waits for any SPI flash transaction to finish.
- It detaches from USB for a fixed interval so the host sees a clean disconnect.
- It then presents the image select and fires `BOOT`.

Optionally, it starts the user image automatically if no USB host appears within a timeout.

## Interface
Parameters:
- `DETACH_CYCLES`, default 480000: cycles the USB detach (SE0) is held before the image select is presented (10 ms at 48 MHz).
- `SETUP_CYCLES`, default 16: cycles `wb_s` is stable before `wb_boot` rises.
- `TIMEOUT_CYCLES`, default 240000000: idle cycles before the automatic user boot (5 s); used only with `WARMBOOT_TIMEOUT_EN`.
- `USER_IMAGE`, default 2'b01: image code used for the automatic boot.

Ports:
- `clk_48mhz`  in  1  single system clock, 48 MHz.
- `reset`  in  1  asynchronous, active-high reset.
- `boot_req`  in  1  single-cycle request from the bootloader core.
- `boot_image`  in  2  image select; sampled only in the cycle `boot_req` is accepted.
- `spi_busy`  in  1  high while a flash SPI transaction is in progress.
- `usb_activity`  in  1  pulses on any valid received USB token.
- `usb_detach`  out  1  forces the USB pads to SE0 with the transmitter disabled.
- `wb_s`  out  2  image select to `SB_WARMBOOT` {S1,S0}.
- `wb_boot`  out  1  drives the `SB_WARMBOOT` `BOOT` input.
- `busy`  out  1  high in every state except `IDLE`.

## Operation
- States: `IDLE`, `DRAIN`, `DETACH`, `SETUP`, `FIRE`.
- `IDLE`: when `boot_req` is high, `boot_image` is latched into `img_q`.
  - If `spi_busy` is low, go to `DETACH`; otherwise go to `DRAIN`.
- `DRAIN`: wait until `spi_busy` is sampled low, then go to `DETACH`. There is no timeout.
- `DETACH`: `usb_detach` is 1. Load the counter with `DETACH_CYCLES`-1; at 0, go to `SETUP`.
- `SETUP`: `wb_s` is `img_q` and `usb_detach` stays 1. Count `SETUP_CYCLES`; at 0, go to `FIRE`.
- `FIRE`: `wb_boot` is 1, and `wb_s` and `usb_detach` are held. This is terminal; only `reset` exits it.
- `boot_req` outside `IDLE` is ignored, and `img_q` is not overwritten.
- `spi_busy` is ignored after `DRAIN`; the bootloader must not start a flash transaction while `busy` is high.
- Counter width is $clog2 of the largest enabled cycle parameter. A parameter value of 0 is illegal and is rejected at elaboration.

## Timing
- Reset values: `usb_detach`=0, `wb_s`=2'b00, `wb_boot`=0, `busy`=0, state `IDLE`, counter 0.
- All outputs are registered, with no combinational path from input to output.
- With `boot_req` accepted in cycle N and `spi_busy` low:
  - `busy` and `usb_detach` rise at N+1.
  - `wb_s` is valid at N+1+`DETACH_CYCLES`.
  - `wb_boot` rises at N+1+`DETACH_CYCLES`+`SETUP_CYCLES`.
- If `spi_busy` is high: `DETACH` is entered one cycle after the first cycle in which `spi_busy` is sampled low.
- Reset asserted mid-sequence: all outputs return to their reset values asynchronously, and the latched image is discarded.

## Configuration
- `WARMBOOT_TIMEOUT_EN` defined:
  - A timeout counter runs in `IDLE` while armed; it is armed at reset.
  - The first `usb_activity` pulse disarms it until the next reset.
  - Reaching `TIMEOUT_CYCLES` acts as a `boot_req` with image `USER_IMAGE`.
  - If `boot_req` coincides with expiry, `boot_req` and its `boot_image` win.
  - `usb_activity` in the expiry cycle disarms the timer and prevents the automatic boot.
- `WARMBOOT_TIMEOUT_EN` undefined:
  - There is no timeout logic; `usb_activity` is unused.
  - Only `boot_req` starts a sequence.

## Structure
- `warmboot_pkg` holds:
  - the state enum;
  - image code constants `IMG_BOOTLOADER`=2'b00 and `IMG_USER`=2'b01;
  - a function computing the counter width from the parameters.
- Sub-module `warmboot_down_counter`: loadable down-counter with a `zero` flag. It is shared by `DETACH`/`SETUP` and instantiated a second time for the timeout.
- `SB_WARMBOOT` is instantiated at board top level, not in this block.

## Test plan
- Basic sequence: `boot_req`, image 2'b10, `spi_busy`=0, `DETACH_CYCLES`=8, `SETUP_CYCLES`=4, request in cycle N → `usb_detach` rises at N+1; `wb_s`=2'b10 at N+9; `wb_boot` rises at N+13 and holds.
- Flash drain: `spi_busy` high for 20 cycles after `boot_req` → `usb_detach` stays 0 through the busy window and rises the cycle after `spi_busy` is sampled low.
- Ignored re-request: a second `boot_req` with image 2'b11 during `DETACH` → `wb_s` still shows the first image; sequence timing is unchanged.
- Mid-operation reset: `reset` pulsed in `SETUP` → all outputs are 0 immediately; a new request restarts the full `DETACH` interval.
- Timeout, `WARMBOOT_TIMEOUT_EN` defined with `TIMEOUT_CYCLES`=100:
  - No activity → sequence starts at cycle 100 with `wb_s`=2'b01.
  - `usb_activity` at cycle 50 → no automatic boot within 1000 cycles.
- Simultaneous events: `boot_req` with image 2'b00 in the expiry cycle → `wb_s`=2'b00.

Source files
------------

// File: rtl/warmboot_pkg.sv
// rtl/warmboot_pkg.sv - shared types, image codes and counter sizing for the warm-boot sequencer
package warmboot_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        DETACH,
        SETUP,
        FIRE
    } state_t;

    localparam logic [1:0] IMG_BOOTLOADER = 2'b00;
    localparam logic [1:0] IMG_USER       = 2'b01;

    // Width must hold (largest cycle count - 1); never narrower than one bit.
    function automatic int counter_width(input int detach_cycles, input int setup_cycles,
                                         input int timeout_cycles, input bit timeout_en);
        int largest;
        int width;
        largest = (detach_cycles > setup_cycles) ? detach_cycles : setup_cycles;
        if (timeout_en && (timeout_cycles > largest)) begin
            largest = timeout_cycles;
        end
        width = $clog2(largest);
        return (width < 1) ? 1 : width;
    endfunction

endpackage

// File: rtl/warmboot_down_counter.sv
// rtl/warmboot_down_counter.sv - loadable saturating down-counter with a zero flag
module warmboot_down_counter #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             en,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= RST_VAL;
        end else if (load) begin
            count <= load_value;
        end else if (en && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/warmboot_sequencer.sv
// rtl/warmboot_sequencer.sv - USB detach then SB_WARMBOOT image select/fire; optional auto user boot under WARMBOOT_TIMEOUT_EN
module warmboot_sequencer
    import warmboot_pkg::*;
#(
    parameter int         DETACH_CYCLES  = 480000,
    parameter int         SETUP_CYCLES   = 16,
    parameter int         TIMEOUT_CYCLES = 240000000,
    parameter logic [1:0] USER_IMAGE     = IMG_USER
) (
    input  logic       clk_48mhz,
    input  logic       reset,
    input  logic       boot_req,
    input  logic [1:0] boot_image,
    input  logic       spi_busy,
    input  logic       usb_activity,
    output logic       usb_detach,
    output logic [1:0] wb_s,
    output logic       wb_boot,
    output logic       busy
);

`ifdef WARMBOOT_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    localparam int CW = counter_width(DETACH_CYCLES, SETUP_CYCLES, TIMEOUT_CYCLES, TIMEOUT_EN);

    if ((DETACH_CYCLES < 1) || (SETUP_CYCLES < 1) || (TIMEOUT_EN && (TIMEOUT_CYCLES < 1))) begin : g_param_check
        $error("warmboot_sequencer: cycle parameters must be nonzero");
    end

    state_t          state;
    state_t          next_state;
    logic [1:0]      img_q;
    logic            img_load;
    logic            ctr_load;
    logic [CW-1:0]   ctr_value;
    logic            ctr_en;
    logic            ctr_zero;
    logic            auto_req;
    logic            start;
    logic [1:0]      start_image;

`ifdef WARMBOOT_TIMEOUT_EN
    logic armed;
    logic to_zero;

    warmboot_down_counter #(
        .WIDTH   (CW),
        .RST_VAL (CW'(TIMEOUT_CYCLES - 1))
    ) u_timeout (
        .clk        (clk_48mhz),
        .rst        (reset),
        .load       (1'b0),
        .load_value ('0),
        .en         ((state == IDLE) && armed && !to_zero),
        .zero       (to_zero)
    );

    // Any host traffic means a bootloader session is live; never auto-boot after that.
    always_ff @(posedge clk_48mhz or posedge reset) begin
        if (reset) begin
            armed <= 1'b1;
        end else if (usb_activity) begin
            armed <= 1'b0;
        end
    end

    assign auto_req = armed && to_zero && !usb_activity;
`else
    logic unused_activity;
    assign unused_activity = usb_activity;
    assign auto_req        = 1'b0;
`endif

    assign start       = boot_req || auto_req;
    assign start_image = boot_req ? boot_image : USER_IMAGE;

    warmboot_down_counter #(
        .WIDTH   (CW),
        .RST_VAL ('0)
    ) u_phase (
        .clk        (clk_48mhz),
        .rst        (reset),
        .load       (ctr_load),
        .load_value (ctr_value),
        .en         (ctr_en),
        .zero       (ctr_zero)
    );

    always_comb begin
        next_state = state;
        img_load   = 1'b0;
        ctr_load   = 1'b0;
        ctr_value  = '0;
        ctr_en     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    img_load = 1'b1;
                    if (!spi_busy) begin
                        next_state = DETACH;
                        ctr_load   = 1'b1;
                        ctr_value  = CW'(DETACH_CYCLES - 1);
                    end else begin
                        next_state = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!spi_busy) begin
                    next_state = DETACH;
                    ctr_load   = 1'b1;
                    ctr_value  = CW'(DETACH_CYCLES - 1);
                end
            end
            DETACH: begin
                if (ctr_zero) begin
                    next_state = SETUP;
                    ctr_load   = 1'b1;
                    ctr_value  = CW'(SETUP_CYCLES - 1);
                end else begin
                    ctr_en = 1'b1;
                end
            end
            SETUP: begin
                if (ctr_zero) begin
                    next_state = FIRE;
                end else begin
                    ctr_en = 1'b1;
                end
            end
            FIRE: begin
                next_state = FIRE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Outputs are registered from next_state so the pads see no decode glitches.
    always_ff @(posedge clk_48mhz or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            img_q      <= IMG_BOOTLOADER;
            usb_detach <= 1'b0;
            wb_s       <= IMG_BOOTLOADER;
            wb_boot    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state <= next_state;
            if (img_load) begin
                img_q <= start_image;
            end
            usb_detach <= (next_state == DETACH) || (next_state == SETUP) || (next_state == FIRE);
            wb_s       <= ((next_state == SETUP) || (next_state == FIRE)) ? img_q : IMG_BOOTLOADER;
            wb_boot    <= (next_state == FIRE);
            busy       <= (next_state != IDLE);
        end
    end

endmodule
